// File: rtl/hop_latency_checker.sv
// Launch-to-arrival latency checker for the two 8-hop flop chains.
// One hop_latency_chan per chain; the top only fans signals in and out
// and merges the per-chain status flags.

// Per-chain checker: edge detect, IDLE/WAIT FSM, latency counter,
// saturating pass/fail counters and sticky flags.
module hop_latency_chan #(
  parameter int EXP_LAT = 9,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 16
) (
  input  logic             clock0,
  input  logic             rst1,
  input  logic             clr,
  input  logic             i_start,
  input  logic             i_arr,
  output logic [CNT_W-1:0] o_pass,
  output logic [CNT_W-1:0] o_fail,
  output logic [4:0]       o_lat,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err,
  output logic             o_ovl
);
  typedef enum logic {S_IDLE, S_WAIT} state_t;

  localparam logic [4:0] EXP5 = 5'(EXP_LAT);
  localparam logic [4:0] TO5  = 5'(TIMEOUT);

  state_t           r_state, w_nxt_state;
  logic             r_start_q, r_arr_q;
  logic [4:0]       r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [4:0]       r_lat, w_lat_nxt;
  logic [CNT_W-1:0] r_pass, r_fail;
  logic             r_done, r_err, r_ovl;
  logic             w_launch, w_arrival;
  logic             w_pass_inc, w_fail_inc, w_resolve, w_ovl_set;

  assign w_launch  = i_start & ~r_start_q;
  assign w_arrival = i_arr & ~r_arr_q;
  assign w_cnt_inc = (r_cnt == 5'd31) ? 5'd31 : r_cnt + 5'd1;

  // Edge registers: only rst1 clears them, so clr never fabricates an edge
  // from a level that was already high.
  always_ff @(posedge clock0 or posedge rst1) begin
    if (rst1) begin
      r_start_q <= 1'b0;
      r_arr_q   <= 1'b0;
    end else begin
      r_start_q <= i_start;
      r_arr_q   <= i_arr;
    end
  end

  // FSM state register.
  always_ff @(posedge clock0 or posedge rst1) begin
    if (rst1)     r_state <= S_IDLE;
    else if (clr) r_state <= S_IDLE;
    else          r_state <= w_nxt_state;
  end

  // Next-state and event decode; arrival wins over timeout and relaunch.
  always_comb begin
    w_nxt_state = r_state;
    w_cnt_nxt   = r_cnt;
    w_lat_nxt   = r_lat;
    w_pass_inc  = 1'b0;
    w_fail_inc  = 1'b0;
    w_resolve   = 1'b0;
    w_ovl_set   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_arrival) w_fail_inc = 1'b1;
        if (w_launch) begin
          w_cnt_nxt   = 5'd0;
          w_nxt_state = S_WAIT;
        end
      end
      S_WAIT: begin
        w_cnt_nxt = w_cnt_inc;
        if (w_launch) w_ovl_set = 1'b1;
        if (w_arrival) begin
          w_lat_nxt   = w_cnt_inc;
          w_pass_inc  = (w_cnt_inc == EXP5);
          w_fail_inc  = (w_cnt_inc != EXP5);
          w_resolve   = 1'b1;
          w_nxt_state = S_IDLE;
        end else if (w_cnt_inc == TO5) begin
          w_lat_nxt   = 5'd31;
          w_fail_inc  = 1'b1;
          w_resolve   = 1'b1;
          w_nxt_state = S_IDLE;
        end
      end
      default: w_nxt_state = S_IDLE;
    endcase
  end

  // Datapath: cycle counter, latency, saturating counters, flags.
  always_ff @(posedge clock0 or posedge rst1) begin
    if (rst1) begin
      r_cnt  <= '0;
      r_lat  <= '0;
      r_pass <= '0;
      r_fail <= '0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
      r_ovl  <= 1'b0;
    end else if (clr) begin
      r_cnt  <= '0;
      r_lat  <= '0;
      r_pass <= '0;
      r_fail <= '0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
      r_ovl  <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_lat  <= w_lat_nxt;
      r_done <= w_resolve;
      if (w_pass_inc && !(&r_pass)) r_pass <= r_pass + 1'b1;
      if (w_fail_inc && !(&r_fail)) r_fail <= r_fail + 1'b1;
      if (w_fail_inc) r_err <= 1'b1;
      if (w_ovl_set)  r_ovl <= 1'b1;
    end
  end

  assign o_pass = r_pass;
  assign o_fail = r_fail;
  assign o_lat  = r_lat;
  assign o_busy = (r_state == S_WAIT);
  assign o_done = r_done;
  assign o_err  = r_err;
  assign o_ovl  = r_ovl;
endmodule

module hop_latency_checker #(
  parameter int EXP_LAT = 9,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 16
) (
  input  logic             clock0,
  input  logic             rst1,
  input  logic             clr,
  input  logic             start_a,
  input  logic             start_b,
  input  logic             arr_a,
  input  logic             arr_b,
  output logic [CNT_W-1:0] pass_a,
  output logic [CNT_W-1:0] fail_a,
  output logic [CNT_W-1:0] pass_b,
  output logic [CNT_W-1:0] fail_b,
  output logic [4:0]       lat_a,
  output logic [4:0]       lat_b,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             ovl
);
  localparam int NUM_LANES = 2;

  logic [NUM_LANES-1:0]            w_start, w_arr, w_busy, w_done, w_err, w_ovl;
  logic [NUM_LANES-1:0][CNT_W-1:0] w_pass, w_fail;
  logic [NUM_LANES-1:0][4:0]       w_lat;

  assign w_start = {start_b, start_a};
  assign w_arr   = {arr_b, arr_a};

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      hop_latency_chan #(
        .EXP_LAT(EXP_LAT), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
      ) u_chan (
        .clock0 (clock0),
        .rst1   (rst1),
        .clr    (clr),
        .i_start(w_start[gi]),
        .i_arr  (w_arr[gi]),
        .o_pass (w_pass[gi]),
        .o_fail (w_fail[gi]),
        .o_lat  (w_lat[gi]),
        .o_busy (w_busy[gi]),
        .o_done (w_done[gi]),
        .o_err  (w_err[gi]),
        .o_ovl  (w_ovl[gi])
      );
    end
  endgenerate

  assign pass_a = w_pass[0];
  assign fail_a = w_fail[0];
  assign lat_a  = w_lat[0];
  assign pass_b = w_pass[1];
  assign fail_b = w_fail[1];
  assign lat_b  = w_lat[1];
  assign busy   = |w_busy;
  assign done   = |w_done;
  assign err    = |w_err;
  assign ovl    = |w_ovl;
endmodule

// File: tb/tb_hop_latency_checker.sv
// Scoreboard bench: each transfer pushes its expected post-resolution
// snapshot; a monitor pops and compares on every done pulse.
module tb_hop_latency_checker;
  localparam int CW = 4;

  logic clock0 = 1'b0, rst1 = 1'b1, clr = 1'b0;
  logic start_a = 1'b0, start_b = 1'b0, arr_a = 1'b0, arr_b = 1'b0;
  logic [CW-1:0] pass_a, fail_a, pass_b, fail_b;
  logic [4:0]    lat_a, lat_b;
  logic          busy, done, err, ovl;

  int n_tests = 0, n_fail = 0;

  typedef struct {
    int pa, fa, pb, fb, la, lb, er, ov;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  hop_latency_checker #(.EXP_LAT(9), .TIMEOUT(15), .CNT_W(CW)) dut (
    .clock0(clock0), .rst1(rst1), .clr(clr),
    .start_a(start_a), .start_b(start_b), .arr_a(arr_a), .arr_b(arr_b),
    .pass_a(pass_a), .fail_a(fail_a), .pass_b(pass_b), .fail_b(fail_b),
    .lat_a(lat_a), .lat_b(lat_b), .busy(busy), .done(done), .err(err), .ovl(ovl)
  );

  always #5 clock0 = ~clock0;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_pass_a"}, int'(pass_a), 0);
    chk({tag, "_fail_a"}, int'(fail_a), 0);
    chk({tag, "_pass_b"}, int'(pass_b), 0);
    chk({tag, "_fail_b"}, int'(fail_b), 0);
    chk({tag, "_lat_a"},  int'(lat_a), 0);
    chk({tag, "_lat_b"},  int'(lat_b), 0);
    chk({tag, "_busy"},   int'(busy), 0);
    chk({tag, "_done"},   int'(done), 0);
    chk({tag, "_err"},    int'(err), 0);
    chk({tag, "_ovl"},    int'(ovl), 0);
  endtask

  task automatic push(input int pa, fa, pb, fb, la, lb, er, ov);
    exp_t e;
    e.pa = pa; e.fa = fa; e.pb = pb; e.fb = fb;
    e.la = la; e.lb = lb; e.er = er; e.ov = ov;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clock0); #1;
  endtask

  // Launch sampled at the next edge k; returns just after edge k.
  task automatic launch(input int ch);
    if (ch == 0) start_a = 1'b1; else start_b = 1'b1;
    tick();
    start_a = 1'b0; start_b = 1'b0;
  endtask

  task automatic arrive(input int ch);
    if (ch == 0) arr_a = 1'b1; else arr_b = 1'b1;
    tick();
    arr_a = 1'b0; arr_b = 1'b0;
  endtask

  // Healthy chain A transfer: arrival sampled 9 edges after launch.
  task automatic good_a();
    launch(0);
    repeat (8) tick();
    arrive(0);
  endtask

  // Monitor: every done pulse must match the oldest expected snapshot.
  always @(negedge clock0) begin
    if (!rst1 && done) begin
      if (sb.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        mon_e = sb.pop_front();
        chk("mon_pass_a", int'(pass_a), mon_e.pa);
        chk("mon_fail_a", int'(fail_a), mon_e.fa);
        chk("mon_pass_b", int'(pass_b), mon_e.pb);
        chk("mon_fail_b", int'(fail_b), mon_e.fb);
        chk("mon_lat_a",  int'(lat_a),  mon_e.la);
        chk("mon_lat_b",  int'(lat_b),  mon_e.lb);
        chk("mon_err",    int'(err),    mon_e.er);
        chk("mon_ovl",    int'(ovl),    mon_e.ov);
      end
    end
  end

  initial begin
    #2;
    chk_zero("reset");
    @(negedge clock0); rst1 = 1'b0;
    tick();

    // Healthy A transfer.
    push(1, 0, 0, 0, 9, 0, 0, 0);
    good_a();
    repeat (3) tick();
    @(negedge clock0);
    chk("t1_busy_idle", int'(busy), 0);
    chk("t1_err", int'(err), 0);

    // B arrives one cycle late, then a spurious arrival.
    push(1, 0, 0, 1, 9, 10, 1, 0);
    launch(1);
    repeat (9) tick();
    arrive(1);
    repeat (2) tick();
    arrive(1);
    @(negedge clock0);
    chk("t2_spur_fail_b", int'(fail_b), 2);
    chk("t2_spur_err", int'(err), 1);
    repeat (2) tick();

    // A timeout: nothing after 14 edges, fail on edge 15.
    push(1, 1, 0, 2, 31, 10, 1, 0);
    launch(0);
    @(negedge clock0);
    chk("t3_busy_wait", int'(busy), 1);
    repeat (14) tick();
    @(negedge clock0);
    chk("t3_pre_to_fail_a", int'(fail_a), 0);
    chk("t3_pre_to_lat_a", int'(lat_a), 9);
    chk("t3_pre_to_busy", int'(busy), 1);
    tick();
    repeat (2) tick();
    @(negedge clock0);
    chk("t3_busy_fall", int'(busy), 0);

    // Relaunch while waiting: ovl set, one transfer counted.
    push(2, 1, 0, 2, 9, 10, 1, 1);
    launch(0);
    repeat (2) tick();
    launch(0);
    repeat (5) tick();
    arrive(0);
    repeat (20) tick();
    @(negedge clock0);
    chk("t4_ovl", int'(ovl), 1);
    chk("t4_pass_a", int'(pass_a), 2);

    // clr with arr_a rising at the same edge and held high afterwards.
    tick();
    clr = 1'b1; arr_a = 1'b1;
    tick();
    clr = 1'b0;
    repeat (2) tick();
    @(negedge clock0);
    chk_zero("t5_clr");
    tick();
    arr_a = 1'b0;
    tick();

    // Async reset with both channels mid-WAIT.
    push(1, 0, 0, 0, 9, 0, 0, 0);
    good_a();
    repeat (2) tick();
    start_a = 1'b1; start_b = 1'b1;
    tick();
    start_a = 1'b0; start_b = 1'b0;
    repeat (4) tick();
    #2 rst1 = 1'b1;
    #1 chk_zero("t6_rst");
    @(negedge clock0); rst1 = 1'b0;
    repeat (20) tick();
    @(negedge clock0);
    chk("t6_no_count_after", int'(fail_a) + int'(fail_b), 0);
    tick();

    // Pass counter saturates at 15 with CNT_W=4.
    for (int i = 1; i <= 16; i++) begin
      push((i > 15) ? 15 : i, 0, 0, 0, 9, 0, 0, 0);
      good_a();
      repeat (2) tick();
    end

    repeat (5) tick();
    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
